conv_layer_sequencer: RTL and testbench

// - Top-level sequencer for one convolution layer: per filter, triggers the kernel loader, then sweeps

---
 rtl/conv_layer_sequencer.sv | 201 ++++++++++++++++++++
 tb/tb_conv_layer_sequencer.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/conv_layer_sequencer.sv
// conv_layer_sequencer: top-level sequencer for one convolution layer.
// For each filter it pulses the kernel loader, waits for the load to finish,
// then issues every valid KxK window top-left address over the IMG_DIM x IMG_DIM
// image. Before advancing to the next filter it waits for the MAC stage to go idle.
// Optional feature: define CONV_SEQ_PERF_EN to add o_stall_cycles, a saturating
// count of SWEEP cycles in which a descriptor was offered but not accepted.
module conv_layer_sequencer #(
    parameter int IMG_DIM         = 28,
    parameter int BRAM_ADDR_WIDTH = 10,
    parameter int FILT_W          = 4
) (
    input  logic                       i_clk,
    input  logic                       i_rst,
    input  logic                       i_start,
    input  logic [2:0]                 i_kernel_size,
    input  logic [FILT_W-1:0]          i_num_filters,
    input  logic [BRAM_ADDR_WIDTH-1:0] i_kernel_base,
    input  logic [BRAM_ADDR_WIDTH-1:0] i_img_base,
    output logic                       o_kl_start,
    output logic [2:0]                 o_kl_size,
    output logic [BRAM_ADDR_WIDTH-1:0] o_kl_addr,
    input  logic                       i_kl_done,
    output logic                       o_win_valid,
    input  logic                       i_win_ready,
    output logic [BRAM_ADDR_WIDTH-1:0] o_win_addr,
    output logic [BRAM_ADDR_WIDTH-1:0] o_win_row,
    output logic [BRAM_ADDR_WIDTH-1:0] o_win_col,
    output logic [FILT_W-1:0]          o_win_filter,
    output logic                       o_win_last,
    input  logic                       i_mac_idle,
    output logic                       o_busy,
    output logic                       o_done,
    output logic                       o_err
`ifdef CONV_SEQ_PERF_EN
    ,
    output logic [15:0]                o_stall_cycles
`endif
);

    localparam int AW = BRAM_ADDR_WIDTH;

    typedef enum logic [2:0] {
        IDLE,
        LOAD_REQ,
        LOAD_WAIT,
        SWEEP,
        DRAIN,
        DONE
    } state_t;

    state_t            state_q, state_d;
    logic [2:0]        k_q, k_d;
    logic [FILT_W-1:0] n_q, n_d;
    logic [FILT_W-1:0] f_q, f_d;
    logic [AW-1:0]     ibase_q, ibase_d;
    logic [AW-1:0]     kl_addr_q, kl_addr_d;
    logic [AW-1:0]     row_q, row_d;
    logic [AW-1:0]     col_q, col_d;
    logic [AW-1:0]     addr_q, addr_d;
    logic              err_q, err_d;

    // K zero-extended to address width; all address math wraps at AW bits.
    logic [AW-1:0] k_ext;
    logic [AW-1:0] kk;
    logic [AW-1:0] last_idx;   // OUT-1 = IMG_DIM-K, last legal row/col index
    logic          start_ok;

    assign k_ext    = {{(AW-3){1'b0}}, k_q};
    assign kk       = k_ext * k_ext;
    assign last_idx = AW'(IMG_DIM) - k_ext;
    assign start_ok = (i_kernel_size != 3'd0) && (i_num_filters != '0);

    // Next-state and datapath updates for the layer sequencing FSM.
    always_comb begin
        state_d   = state_q;
        k_d       = k_q;
        n_d       = n_q;
        f_d       = f_q;
        ibase_d   = ibase_q;
        kl_addr_d = kl_addr_q;
        row_d     = row_q;
        col_d     = col_q;
        addr_d    = addr_q;
        err_d     = 1'b0;
        case (state_q)
            IDLE: begin
                if (i_start) begin
                    k_d     = i_kernel_size;
                    n_d     = i_num_filters;
                    ibase_d = i_img_base;
                    if (!start_ok) begin
                        err_d = 1'b1;
                    end else begin
                        f_d       = '0;
                        kl_addr_d = i_kernel_base;
                        state_d   = LOAD_REQ;
                    end
                end
            end
            LOAD_REQ: state_d = LOAD_WAIT;
            LOAD_WAIT: begin
                if (i_kl_done) begin
                    row_d   = '0;
                    col_d   = '0;
                    addr_d  = ibase_q;
                    state_d = SWEEP;
                end
            end
            SWEEP: begin
                if (i_win_ready) begin
                    if (col_q == last_idx) begin
                        // Row wrap: skipping the K-1 columns that cannot start a window.
                        col_d  = '0;
                        row_d  = row_q + 1'b1;
                        addr_d = addr_q + k_ext;
                        if (row_q == last_idx) state_d = DRAIN;
                    end else begin
                        col_d  = col_q + 1'b1;
                        addr_d = addr_q + 1'b1;
                    end
                end
            end
            DRAIN: begin
                // Kernel registers must not be reloaded while the MAC still uses them.
                if (i_mac_idle) begin
                    if (FILT_W'(f_q + 1'b1) == n_q) begin
                        state_d = DONE;
                    end else begin
                        f_d       = f_q + 1'b1;
                        kl_addr_d = kl_addr_q + kk;
                        state_d   = LOAD_REQ;
                    end
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers; reset aborts any layer in progress.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q   <= IDLE;
            k_q       <= '0;
            n_q       <= '0;
            f_q       <= '0;
            ibase_q   <= '0;
            kl_addr_q <= '0;
            row_q     <= '0;
            col_q     <= '0;
            addr_q    <= '0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            k_q       <= k_d;
            n_q       <= n_d;
            f_q       <= f_d;
            ibase_q   <= ibase_d;
            kl_addr_q <= kl_addr_d;
            row_q     <= row_d;
            col_q     <= col_d;
            addr_q    <= addr_d;
            err_q     <= err_d;
        end
    end

    assign o_kl_start   = (state_q == LOAD_REQ);
    assign o_kl_size    = k_q;
    assign o_kl_addr    = kl_addr_q;
    assign o_win_valid  = (state_q == SWEEP);
    assign o_win_addr   = addr_q;
    assign o_win_row    = row_q;
    assign o_win_col    = col_q;
    assign o_win_filter = f_q;
    assign o_win_last   = o_win_valid && (row_q == last_idx) && (col_q == last_idx);
    assign o_busy       = (state_q != IDLE);
    assign o_done       = (state_q == DONE);
    assign o_err        = err_q;

`ifdef CONV_SEQ_PERF_EN
    logic [15:0] stall_q, stall_d;

    // Stall counter: restarts on a legal start, saturates rather than wrapping.
    always_comb begin
        stall_d = stall_q;
        if (state_q == IDLE && i_start && start_ok)
            stall_d = '0;
        else if (state_q == SWEEP && !i_win_ready && stall_q != 16'hFFFF)
            stall_d = stall_q + 16'd1;
    end

    // Stall counter register.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) stall_q <= '0;
        else       stall_q <= stall_d;
    end

    assign o_stall_cycles = stall_q;
`endif

endmodule

// File: tb/tb_conv_layer_sequencer.sv
// Scoreboard bench for conv_layer_sequencer: runs whole layers, queues the
// expected kernel loads and window descriptors from a plain loop model, and
// a monitor compares every load pulse and accepted descriptor against them.
module tb_conv_layer_sequencer;
    localparam int AW  = 10;
    localparam int FW  = 4;
    localparam int DIM = 28;

    logic          clk, rst, start;
    logic [2:0]    ksize;
    logic [FW-1:0] nfilt;
    logic [AW-1:0] kbase, ibase;
    logic          kl_start, kl_done, win_valid, win_ready, win_last, mac_idle;
    logic [2:0]    kl_size;
    logic [AW-1:0] kl_addr, win_addr, win_row, win_col;
    logic [FW-1:0] win_filter;
    logic          busy, done, err;
`ifdef CONV_SEQ_PERF_EN
    logic [15:0]   stall_cycles;
`endif

    conv_layer_sequencer #(.IMG_DIM(DIM), .BRAM_ADDR_WIDTH(AW), .FILT_W(FW)) dut (
        .i_clk(clk), .i_rst(rst), .i_start(start), .i_kernel_size(ksize),
        .i_num_filters(nfilt), .i_kernel_base(kbase), .i_img_base(ibase),
        .o_kl_start(kl_start), .o_kl_size(kl_size), .o_kl_addr(kl_addr),
        .i_kl_done(kl_done), .o_win_valid(win_valid), .i_win_ready(win_ready),
        .o_win_addr(win_addr), .o_win_row(win_row), .o_win_col(win_col),
        .o_win_filter(win_filter), .o_win_last(win_last), .i_mac_idle(mac_idle),
        .o_busy(busy), .o_done(done), .o_err(err)
`ifdef CONV_SEQ_PERF_EN
        , .o_stall_cycles(stall_cycles)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [AW-1:0] row;
        logic [AW-1:0] col;
        logic [FW-1:0] filt;
        logic          last;
    } win_t;

    win_t          win_q[$];
    logic [AW-1:0] kl_q[$];
    logic [2:0]    kl_size_exp;
    int errors = 0, checks = 0;
    int done_cnt = 0, err_cnt = 0, kl_cnt = 0, stall_obs = 0;
    int kl_delay = 0, mac_hold = 0;
    bit ready_rand = 0, mac_hold_en = 0;

    task automatic chk(input bit ok, input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: every filter loads from base+f*K*K, then visits all
    // (OUT x OUT) window positions row-major; address = base + row*DIM + col.
    task automatic push_layer(input int k, input int n, input int kb, input int ib);
        int outd;
        win_t w;
        outd = DIM - k + 1;
        for (int f = 0; f < n; f++) begin
            kl_q.push_back(AW'((kb + f * k * k) % (1 << AW)));
            for (int r = 0; r < outd; r++)
                for (int c = 0; c < outd; c++) begin
                    w.addr = AW'((ib + r * DIM + c) % (1 << AW));
                    w.row  = AW'(r);
                    w.col  = AW'(c);
                    w.filt = FW'(f);
                    w.last = (r == outd - 1) && (c == outd - 1);
                    win_q.push_back(w);
                end
        end
    endtask

    // Input drivers: window ready, kernel loader response, MAC idle.
    initial begin
        win_ready = 1'b0; kl_done = 1'b0; mac_idle = 1'b1;
        forever begin
            @(negedge clk);
            win_ready = ready_rand ? ($urandom_range(0, 99) < 60) : 1'b1;
            if (kl_delay > 0) begin
                kl_delay--;
                kl_done = (kl_delay == 0);
            end else begin
                kl_done = win_valid && ($urandom_range(0, 15) == 0);
            end
            if (mac_hold > 0) begin
                mac_hold--;
                mac_idle = 1'b0;
            end else begin
                mac_idle = 1'b1;
            end
        end
    end

    // Monitor: samples just before each rising edge, pops and compares.
    initial begin
        win_t cur, prev, e;
        logic [AW-1:0] ea;
        bit have_prev;
        have_prev = 0;
        forever begin
            @(negedge clk);
            #4;
            if (rst) begin
                have_prev = 0;
                continue;
            end
            cur = '{addr: win_addr, row: win_row, col: win_col, filt: win_filter, last: win_last};
            if (kl_start) begin
                kl_cnt++;
                if (kl_q.size() == 0) begin
                    chk(0, "kl_extra", 64'(kl_addr), 0);
                end else begin
                    ea = kl_q.pop_front();
                    chk(kl_addr == ea, "kl_addr", 64'(kl_addr), 64'(ea));
                    chk(kl_size == kl_size_exp, "kl_size", 64'(kl_size), 64'(kl_size_exp));
                end
                chk(mac_hold == 0, "kl_while_mac_busy", 64'(mac_hold), 0);
                kl_delay = $urandom_range(1, 4);
            end
            if (have_prev && win_valid)
                chk(cur == prev, "stall_stable", 64'(cur), 64'(prev));
            have_prev = 0;
            if (win_valid) begin
                if (win_ready) begin
                    if (win_q.size() == 0) begin
                        chk(0, "win_extra", 64'(cur), 0);
                    end else begin
                        e = win_q.pop_front();
                        chk(cur == e, "win_desc", 64'(cur), 64'(e));
                    end
                    if (win_last && mac_hold_en) mac_hold = 50;
                end else begin
                    stall_obs++;
                    prev = cur;
                    have_prev = 1;
                end
            end
            if (done) begin
                done_cnt++;
                chk(win_q.size() == 0 && kl_q.size() == 0, "done_early",
                    64'(win_q.size() + kl_q.size()), 0);
                chk(mac_hold == 0, "done_while_mac_busy", 64'(mac_hold), 0);
            end
            if (err) err_cnt++;
        end
    end

    task automatic drive_start(input int k, input int n, input int kb, input int ib);
        @(negedge clk);
        start = 1'b1; ksize = 3'(k); nfilt = FW'(n); kbase = AW'(kb); ibase = AW'(ib);
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic run_layer(input int k, input int n, input int kb, input int ib,
                             input bit rr, input bit hold, input bit poke);
        int d0, cyc;
        ready_rand = rr; mac_hold_en = hold;
        kl_size_exp = 3'(k);
        push_layer(k, n, kb, ib);
        stall_obs = 0;
        d0 = done_cnt;
        drive_start(k, n, kb, ib);
        cyc = 0;
        while (done_cnt == d0 && cyc < 20000) begin
            @(negedge clk);
            cyc++;
            if (poke && cyc == 300) begin
                start = 1'b1; ksize = 3'd2; nfilt = 4'd5; kbase = 10'd7; ibase = 10'd9;
            end else begin
                start = 1'b0;
            end
        end
        chk(done_cnt == d0 + 1, "done_count", 64'(done_cnt - d0), 1);
        #4;
        chk(!busy, "busy_after_done", 64'(busy), 0);
        chk(win_q.size() == 0 && kl_q.size() == 0, "queues_empty",
            64'(win_q.size() + kl_q.size()), 0);
`ifdef CONV_SEQ_PERF_EN
        chk(stall_cycles == 16'(stall_obs), "stall_cycles", 64'(stall_cycles), 64'(stall_obs));
`endif
        repeat (3) @(negedge clk);
        chk(done_cnt == d0 + 1, "single_done", 64'(done_cnt - d0), 1);
        ready_rand = 0; mac_hold_en = 0;
    endtask

    task automatic bad_start(input int k, input int n);
        int e0, k0;
        e0 = err_cnt; k0 = kl_cnt;
        drive_start(k, n, 5, 5);
        #4;
        chk(err, "err_pulse", 64'(err), 1);
        chk(!busy, "err_busy", 64'(busy), 0);
        repeat (5) @(negedge clk);
        #4;
        chk(err_cnt == e0 + 1, "err_count", 64'(err_cnt - e0), 1);
        chk(kl_cnt == k0, "err_no_kl", 64'(kl_cnt - k0), 0);
        chk(!busy && !err, "err_idle", 64'({busy, err}), 0);
    endtask

    function automatic logic [63:0] all_outs();
        return 64'({kl_start, kl_size, kl_addr, win_valid, win_addr, win_row, win_col,
                    win_filter, win_last, busy, done, err});
    endfunction

    task automatic reset_mid_sweep();
        int cyc, total;
        kl_size_exp = 3'd4;
        push_layer(4, 2, 30, 60);
        total = win_q.size();
        drive_start(4, 2, 30, 60);
        cyc = 0;
        while (win_q.size() > total - 150 && cyc < 5000) begin
            @(negedge clk);
            cyc++;
        end
        chk(cyc < 5000, "reach_sweep", 64'(cyc), 0);
        #2 rst = 1'b1;
        #1;
        chk(all_outs() == 0, "async_reset_outs", all_outs(), 0);
`ifdef CONV_SEQ_PERF_EN
        chk(stall_cycles == 0, "async_reset_stall", 64'(stall_cycles), 0);
`endif
        win_q.delete(); kl_q.delete();
        kl_delay = 0; mac_hold = 0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        int k, n;
        rst = 1'b1; start = 1'b0; ksize = '0; nfilt = '0; kbase = '0; ibase = '0;
        #1;
        chk(all_outs() == 0, "reset_outs", all_outs(), 0);
        repeat (3) @(negedge clk);
        rst = 1'b0;

        run_layer(3, 1, 200, 100, 0, 0, 0);
        run_layer(5, 3, 0, 0, 0, 0, 1);
        bad_start(0, 2);
        bad_start(3, 0);
        run_layer(7, 2, 1015, 17, 1, 0, 0);
        run_layer(7, 2, 40, 300, 0, 1, 0);
        run_layer(1, 1, 0, 1000, 1, 0, 0);
        reset_mid_sweep();
        run_layer(4, 2, 30, 60, 0, 0, 0);
        for (int i = 0; i < 2; i++) begin
            k = $urandom_range(1, 7);
            n = $urandom_range(1, 2);
            run_layer(k, n, $urandom_range(0, 1023), $urandom_range(0, 1023), 1, 0, 0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
